// File: rtl/ifu_cache_pkg.sv
// Shared types and width helpers for the set-associative instruction cache.
// Holds the controller state encoding and the address-split width functions.
// Pure declarations; no logic.
package ifu_cache_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOOKUP    = 3'd1,
    ST_MISS_REQ  = 3'd2,
    ST_MISS_WAIT = 3'd3,
    ST_FILL      = 3'd4
  } t_ifu_cache_state;

  // Address bits consumed by the set index (0 for a single-set cache).
  function automatic int ifu_idx_bits(input int num_sets);
    return (num_sets > 1) ? $clog2(num_sets) : 0;
  endfunction

  // Storage width of the set index; at least one bit so it can be declared.
  function automatic int ifu_idx_w(input int num_sets);
    return (num_sets > 1) ? $clog2(num_sets) : 1;
  endfunction

  function automatic int ifu_tag_w(input int addr_w, input int off_w, input int num_sets);
    return addr_w - off_w - ifu_idx_bits(num_sets);
  endfunction

  function automatic int ifu_way_w(input int num_ways);
    return $clog2(num_ways);
  endfunction

endpackage

// File: rtl/ifu_plru_tree.sv
// Tree pseudo-LRU for one set: victim way from the tree bits, and the updated
// bits after touching a way. Purely combinational. Node n has children 2n+1/2n+2;
// a bit of 0 means the victim lies in the left subtree.
module ifu_plru_tree #(
  parameter int NUM_WAYS = 4
) (
  input  logic [NUM_WAYS-2:0]         tree_i,
  input  logic [$clog2(NUM_WAYS)-1:0] access_way_i,
  output logic [NUM_WAYS-2:0]         tree_o,
  output logic [$clog2(NUM_WAYS)-1:0] victim_o
);

  localparam int LVL = $clog2(NUM_WAYS);

  logic [LVL-1:0] vic_node;
  logic [LVL-1:0] upd_node;
  logic           vic_bit;
  logic           way_bit;

  // Follow the tree bits from the root down to the least recently used leaf.
  always_comb begin
    vic_node = '0;
    vic_bit  = 1'b0;
    victim_o = '0;
    for (int l = 0; l < LVL; l++) begin
      vic_bit             = tree_i[vic_node];
      victim_o[LVL-1-l]   = vic_bit;
      vic_node            = LVL'((32'(vic_node) << 1) + 32'd1 + 32'(vic_bit));
    end
  end

  // Walk the accessed way's path, turning every node to point away from it.
  always_comb begin
    tree_o   = tree_i;
    upd_node = '0;
    way_bit  = 1'b0;
    for (int l = 0; l < LVL; l++) begin
      way_bit          = access_way_i[LVL-1-l];
      tree_o[upd_node] = ~way_bit;
      upd_node         = LVL'((32'(upd_node) << 1) + 32'd1 + 32'(way_bit));
    end
  end

endmodule

// File: rtl/ifu_sa_cache.sv
// Blocking set-associative instruction cache: one outstanding fetch, tree-PLRU
// replacement, hit response two cycles after acceptance, miss fetched over a
// valid/ready line request and returned one cycle after the fill.
module ifu_sa_cache
  import ifu_cache_pkg::*;
#(
  parameter int NUM_WAYS     = 4,
  parameter int NUM_SETS     = 4,
  parameter int LINE_WIDTH   = 128,
  parameter int ADDR_WIDTH   = 32,
  parameter int OFFSET_WIDTH = 4
) (
  input  logic                         Clock,
  input  logic                         Rst,
  input  logic                         cpu_reqValidIn,
  output logic                         cpu_reqReadyOut,
  input  logic [ADDR_WIDTH-1:0]        cpu_reqAddrIn,
  output logic                         cpu_rspValidOut,
  output logic [ADDR_WIDTH-1:0]        cpu_rspAddrOut,
  output logic [LINE_WIDTH-1:0]        cpu_rspInsLineOut,
  output logic                         mem_reqValidOut,
  input  logic                         mem_reqReadyIn,
  output logic [ADDR_WIDTH-OFFSET_WIDTH-1:0] mem_reqAddrOut,
  input  logic                         mem_rspValidIn,
  input  logic [LINE_WIDTH-1:0]        mem_rspInsLineIn,
  input  logic                         flushIn
);

  localparam int WAY_W  = ifu_way_w(NUM_WAYS);
  localparam int IDX_B  = ifu_idx_bits(NUM_SETS);
  localparam int IDX_W  = ifu_idx_w(NUM_SETS);
  localparam int TAG_W  = ifu_tag_w(ADDR_WIDTH, OFFSET_WIDTH, NUM_SETS);
  localparam int TREE_W = NUM_WAYS - 1;

  t_ifu_cache_state state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  rsp_vld_q;
  logic [ADDR_WIDTH-1:0] rsp_addr_q;
  logic [LINE_WIDTH-1:0] rsp_line_q;

  logic [NUM_WAYS-1:0]   valid_q [NUM_SETS];
  logic [TREE_W-1:0]     plru_q  [NUM_SETS];
  logic [TAG_W-1:0]      tag_q   [NUM_SETS][NUM_WAYS];
  logic [LINE_WIDTH-1:0] data_q  [NUM_SETS][NUM_WAYS];

  logic [IDX_W-1:0]  set_idx;
  logic [TAG_W-1:0]  cur_tag;
  logic              hit;
  logic [WAY_W-1:0]  hit_way;
  logic              has_inv;
  logic [WAY_W-1:0]  inv_way;
  logic [WAY_W-1:0]  plru_victim;
  logic [WAY_W-1:0]  fill_way;
  logic [WAY_W-1:0]  access_way;
  logic [TREE_W-1:0] plru_next;
  logic              fill_now;

  // The mask folds the index to zero for a single-set cache.
  assign set_idx  = IDX_W'(addr_q >> OFFSET_WIDTH) & IDX_W'(NUM_SETS - 1);
  assign cur_tag  = TAG_W'(addr_q >> (OFFSET_WIDTH + IDX_B));
  assign fill_now = (state_q == ST_MISS_WAIT) && mem_rspValidIn;

  assign cpu_reqReadyOut   = (state_q == ST_IDLE) && !flushIn;
  assign mem_reqValidOut   = (state_q == ST_MISS_REQ);
  assign mem_reqAddrOut    = addr_q[ADDR_WIDTH-1:OFFSET_WIDTH];
  assign cpu_rspValidOut   = rsp_vld_q;
  assign cpu_rspAddrOut    = rsp_addr_q;
  assign cpu_rspInsLineOut = rsp_line_q;

  // Tag compare and lowest-index invalid search; descending scan so way 0 wins.
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    has_inv = 1'b0;
    inv_way = '0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (valid_q[set_idx][w] && (tag_q[set_idx][w] == cur_tag)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!valid_q[set_idx][w]) begin
        has_inv = 1'b1;
        inv_way = WAY_W'(w);
      end
    end
  end

  assign fill_way   = has_inv ? inv_way : plru_victim;
  assign access_way = (state_q == ST_LOOKUP) ? hit_way : fill_way;

  ifu_plru_tree #(
    .NUM_WAYS(NUM_WAYS)
  ) u_plru (
    .tree_i      (plru_q[set_idx]),
    .access_way_i(access_way),
    .tree_o      (plru_next),
    .victim_o    (plru_victim)
  );

  // Next-state selection for the single-outstanding fetch controller.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      if (!flushIn && cpu_reqValidIn) state_d = ST_LOOKUP;
      ST_LOOKUP:    state_d = hit ? ST_IDLE : ST_MISS_REQ;
      ST_MISS_REQ:  if (mem_reqReadyIn) state_d = ST_MISS_WAIT;
      ST_MISS_WAIT: if (mem_rspValidIn) state_d = ST_FILL;
      ST_FILL:      state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  // Controller, response registers, valid and PLRU bits; all cleared by reset.
  always_ff @(posedge Clock or posedge Rst) begin
    if (Rst) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      rsp_vld_q  <= 1'b0;
      rsp_addr_q <= '0;
      rsp_line_q <= '0;
      for (int s = 0; s < NUM_SETS; s++) begin
        valid_q[s] <= '0;
        plru_q[s]  <= '0;
      end
    end else begin
      state_q   <= state_d;
      rsp_vld_q <= 1'b0;
      if (cpu_reqReadyOut && cpu_reqValidIn) begin
        addr_q <= cpu_reqAddrIn;
      end
      if ((state_q == ST_IDLE) && flushIn) begin
        for (int s = 0; s < NUM_SETS; s++) begin
          valid_q[s] <= '0;
          plru_q[s]  <= '0;
        end
      end
      if ((state_q == ST_LOOKUP) && hit) begin
        rsp_vld_q       <= 1'b1;
        rsp_addr_q      <= addr_q;
        rsp_line_q      <= data_q[set_idx][hit_way];
        plru_q[set_idx] <= plru_next;
      end
      if (fill_now) begin
        valid_q[set_idx][fill_way] <= 1'b1;
        plru_q[set_idx]            <= plru_next;
        rsp_addr_q                 <= addr_q;
        rsp_line_q                 <= mem_rspInsLineIn;
      end
      if (state_q == ST_FILL) begin
        rsp_vld_q <= 1'b1;
      end
    end
  end

  // Line and tag storage carry no reset; the valid bits gate every use.
  always_ff @(posedge Clock) begin
    if (fill_now) begin
      data_q[set_idx][fill_way] <= mem_rspInsLineIn;
      tag_q[set_idx][fill_way]  <= cur_tag;
    end
  end

endmodule

// File: tb/tb_ifu_sa_cache.sv
// Directed bench for ifu_sa_cache: table of fetch transactions with expected
// hit/miss and line, plus hand sequences for flush, backpressure, stray
// responses and reset during an outstanding miss.
module tb_ifu_sa_cache;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         cpu_reqValidIn = 1'b0;
  logic         cpu_reqReadyOut;
  logic [31:0]  cpu_reqAddrIn = '0;
  logic         cpu_rspValidOut;
  logic [31:0]  cpu_rspAddrOut;
  logic [127:0] cpu_rspInsLineOut;
  logic         mem_reqValidOut;
  logic         mem_reqReadyIn = 1'b1;
  logic [27:0]  mem_reqAddrOut;
  logic         mem_rspValidIn = 1'b0;
  logic [127:0] mem_rspInsLineIn = '0;
  logic         flushIn = 1'b0;

  always #5 clk = ~clk;

  ifu_sa_cache #(
    .NUM_WAYS(4), .NUM_SETS(4), .LINE_WIDTH(128), .ADDR_WIDTH(32), .OFFSET_WIDTH(4)
  ) dut (
    .Clock            (clk),
    .Rst              (rst),
    .cpu_reqValidIn   (cpu_reqValidIn),
    .cpu_reqReadyOut  (cpu_reqReadyOut),
    .cpu_reqAddrIn    (cpu_reqAddrIn),
    .cpu_rspValidOut  (cpu_rspValidOut),
    .cpu_rspAddrOut   (cpu_rspAddrOut),
    .cpu_rspInsLineOut(cpu_rspInsLineOut),
    .mem_reqValidOut  (mem_reqValidOut),
    .mem_reqReadyIn   (mem_reqReadyIn),
    .mem_reqAddrOut   (mem_reqAddrOut),
    .mem_rspValidIn   (mem_rspValidIn),
    .mem_rspInsLineIn (mem_rspInsLineIn),
    .flushIn          (flushIn)
  );

  typedef struct {
    logic         rst_before;
    logic [31:0]  addr;
    logic         exp_hit;
    logic [127:0] fill;
    logic [127:0] exp_line;
  } vec_t;

  vec_t vecs[32];
  int   nv = 0;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  logic         t_hit, t_got, t_once;
  logic [127:0] t_line;
  logic [31:0]  t_raddr;
  logic [27:0]  t_maddr;
  int           t_lat;

  function automatic logic [127:0] mk(input logic [31:0] w);
    return {w, w, w, w};
  endfunction

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %h, expected %h", nm, got, exp);
  endtask

  task automatic add(input logic r, input logic [31:0] a, input logic h,
                     input logic [127:0] f, input logic [127:0] e);
    vecs[nv].rst_before = r;
    vecs[nv].addr       = a;
    vecs[nv].exp_hit    = h;
    vecs[nv].fill       = f;
    vecs[nv].exp_line   = e;
    nv++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One fetch from a negedge; memory answers one cycle after the handshake.
  // bp>0 holds mem_reqReadyIn low and checks the request stays stable.
  task automatic txn(input logic [31:0] a, input logic [127:0] fill, input int bp,
                     output logic hit, output logic [127:0] line, output logic [31:0] raddr,
                     output logic [27:0] maddr, output int lat, output logic got,
                     output logic once);
    int miss_c;
    hit = 1'b1; line = '0; raddr = '0; maddr = '0; lat = 0; got = 1'b0; once = 1'b0;
    miss_c = -1;
    mem_reqReadyIn   = (bp == 0);
    mem_rspInsLineIn = fill;
    mem_rspValidIn   = 1'b0;
    cpu_reqAddrIn    = a;
    cpu_reqValidIn   = 1'b1;
    for (int k = 0; k < 20 && !cpu_reqReadyOut; k++) @(negedge clk);
    @(negedge clk);
    cpu_reqValidIn = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      if (cpu_rspValidOut) begin
        got = 1'b1; line = cpu_rspInsLineOut; raddr = cpu_rspAddrOut; lat = c;
        break;
      end
      if (miss_c < 0 && mem_reqValidOut) begin
        miss_c = c; hit = 1'b0; maddr = mem_reqAddrOut;
      end else if (miss_c >= 0 && c <= miss_c + bp) begin
        chk($sformatf("bp_hold_c%0d", c), {mem_reqValidOut, mem_reqAddrOut}, {1'b1, maddr});
      end
      if (miss_c >= 0 && c == miss_c + bp) mem_reqReadyIn = 1'b1;
      mem_rspValidIn = (miss_c >= 0 && c == miss_c + bp + 1);
      @(negedge clk);
    end
    mem_rspValidIn = 1'b0;
    mem_reqReadyIn = 1'b1;
    if (got) begin
      @(negedge clk);
      once = !cpu_rspValidOut;
    end
  endtask

  initial begin
    logic acc;
    // Cold miss then hit.
    add(1, 32'h0000_1000, 0, mk(32'hDEADBEEF), mk(32'hDEADBEEF));
    add(0, 32'h0000_1000, 1, '0,               mk(32'hDEADBEEF));
    // Fill order, PLRU eviction of way 0, set independence (0x0010 is set 1).
    add(1, 32'h0000_0010, 0, mk(32'hC0DE0007), mk(32'hC0DE0007));
    add(0, 32'h0000_0000, 0, mk(32'hC0DE0000), mk(32'hC0DE0000));
    add(0, 32'h0000_0040, 0, mk(32'hC0DE0001), mk(32'hC0DE0001));
    add(0, 32'h0000_0080, 0, mk(32'hC0DE0002), mk(32'hC0DE0002));
    add(0, 32'h0000_00C0, 0, mk(32'hC0DE0003), mk(32'hC0DE0003));
    add(0, 32'h0000_0100, 0, mk(32'hC0DE0004), mk(32'hC0DE0004));
    add(0, 32'h0000_0000, 0, mk(32'hC0DE0005), mk(32'hC0DE0005));
    add(0, 32'h0000_0040, 1, '0,               mk(32'hC0DE0001));
    add(0, 32'h0000_00C0, 1, '0,               mk(32'hC0DE0003));
    add(0, 32'h0000_0100, 1, '0,               mk(32'hC0DE0004));
    add(0, 32'h0000_0010, 1, '0,               mk(32'hC0DE0007));
    // A hit on way 0 steers the next eviction to way 2.
    add(1, 32'h0000_0000, 0, mk(32'hC0DE0000), mk(32'hC0DE0000));
    add(0, 32'h0000_0040, 0, mk(32'hC0DE0001), mk(32'hC0DE0001));
    add(0, 32'h0000_0080, 0, mk(32'hC0DE0002), mk(32'hC0DE0002));
    add(0, 32'h0000_00C0, 0, mk(32'hC0DE0003), mk(32'hC0DE0003));
    add(0, 32'h0000_0000, 1, '0,               mk(32'hC0DE0000));
    add(0, 32'h0000_0100, 0, mk(32'hC0DE0004), mk(32'hC0DE0004));
    add(0, 32'h0000_0080, 0, mk(32'hC0DE0006), mk(32'hC0DE0006));
    add(0, 32'h0000_0000, 1, '0,               mk(32'hC0DE0000));
    add(0, 32'h0000_00C0, 1, '0,               mk(32'hC0DE0003));

    // Reset state.
    #1 rst = 1'b1;
    #1;
    chk("rst_during_vld", {cpu_rspValidOut, mem_reqValidOut}, 2'b00);
    chk("rst_during_addr", {mem_reqAddrOut, cpu_rspAddrOut}, '0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_after", {cpu_reqReadyOut, mem_reqValidOut, cpu_rspValidOut}, 3'b100);
    chk("rst_line", cpu_rspInsLineOut, '0);

    for (int i = 0; i < nv; i++) begin
      if (vecs[i].rst_before) do_reset();
      txn(vecs[i].addr, vecs[i].fill, 0, t_hit, t_line, t_raddr, t_maddr, t_lat, t_got, t_once);
      chk($sformatf("v%0d_rsp_seen", i), t_got, 1'b1);
      chk($sformatf("v%0d_hit", i), t_hit, vecs[i].exp_hit);
      chk($sformatf("v%0d_line", i), t_line, vecs[i].exp_line);
      chk($sformatf("v%0d_rsp_addr", i), t_raddr, vecs[i].addr);
      if (!vecs[i].exp_hit) chk($sformatf("v%0d_mem_addr", i), t_maddr, vecs[i].addr >> 4);
      else chk($sformatf("v%0d_hit_lat", i), t_lat, 2);
      chk($sformatf("v%0d_one_pulse", i), t_once, 1'b1);
    end

    // Flush in IDLE blocks acceptance that cycle and drops every line.
    @(negedge clk);
    flushIn = 1'b1; cpu_reqValidIn = 1'b1; cpu_reqAddrIn = 32'h0;
    #1 chk("flush_ready_low", cpu_reqReadyOut, 1'b0);
    @(negedge clk);
    flushIn = 1'b0; cpu_reqValidIn = 1'b0;
    #1 chk("flush_not_accepted", {cpu_reqReadyOut, mem_reqValidOut}, 2'b10);
    txn(32'h0000_0000, mk(32'hC0DE0008), 0, t_hit, t_line, t_raddr, t_maddr, t_lat, t_got, t_once);
    chk("flush_miss0", t_hit, 1'b0);
    chk("flush_line0", t_line, mk(32'hC0DE0008));
    txn(32'h0000_00C0, mk(32'hC0DE000C), 0, t_hit, t_line, t_raddr, t_maddr, t_lat, t_got, t_once);
    chk("flush_missC0", t_hit, 1'b0);

    // Backpressure on the memory request.
    txn(32'h0000_3040, mk(32'hC0DE0009), 5, t_hit, t_line, t_raddr, t_maddr, t_lat, t_got, t_once);
    chk("bp_miss", t_hit, 1'b0);
    chk("bp_mem_addr", t_maddr, 28'h304);
    chk("bp_line", t_line, mk(32'hC0DE0009));

    // Stray memory response while idle is ignored.
    mem_rspInsLineIn = mk(32'hBAD0BAD0);
    mem_rspValidIn = 1'b1;
    acc = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      acc = acc | cpu_rspValidOut | mem_reqValidOut | !cpu_reqReadyOut;
    end
    mem_rspValidIn = 1'b0;
    chk("stray_quiet", acc, 1'b0);
    txn(32'h0000_3040, '0, 0, t_hit, t_line, t_raddr, t_maddr, t_lat, t_got, t_once);
    chk("stray_hit", t_hit, 1'b1);
    chk("stray_line", t_line, mk(32'hC0DE0009));

    // Reset while waiting for the memory response.
    @(negedge clk);
    cpu_reqValidIn = 1'b1; cpu_reqAddrIn = 32'h0000_2000;
    @(negedge clk);
    cpu_reqValidIn = 1'b0;
    for (int k = 0; k < 10 && !mem_reqValidOut; k++) @(negedge clk);
    chk("mr_req_seen", mem_reqValidOut, 1'b1);
    chk("mr_req_addr", mem_reqAddrOut, 28'h200);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mr_rst_vld", {cpu_rspValidOut, mem_reqValidOut}, 2'b00);
    chk("mr_rst_addr", mem_reqAddrOut, '0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("mr_ready", cpu_reqReadyOut, 1'b1);
    mem_rspInsLineIn = mk(32'hBAD1BAD1);
    mem_rspValidIn = 1'b1;
    @(negedge clk);
    mem_rspValidIn = 1'b0;
    acc = 1'b0;
    for (int k = 0; k < 4; k++) begin
      acc = acc | cpu_rspValidOut;
      @(negedge clk);
    end
    chk("mr_no_rsp", acc, 1'b0);
    txn(32'h0000_3040, mk(32'hC0DE000A), 0, t_hit, t_line, t_raddr, t_maddr, t_lat, t_got, t_once);
    chk("mr_valid_cleared", t_hit, 1'b0);
    chk("mr_refill_line", t_line, mk(32'hC0DE000A));

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
